// File: rtl/raster_stamp_queue_if.sv
// Push, pop and CSR-read bundle for the per-warp raster stamp queue.
// The master drives beats and read selects; the slave (queue) answers.
interface raster_stamp_queue_if #(
  parameter int unsigned NUM_WARPS   = 4,
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned NUM_LANES   = 4,
  parameter int unsigned POS_BITS    = 15,
  parameter int unsigned NUM_BCOORDS = 3
);
  localparam int unsigned NUM_PIDS = NUM_THREADS / NUM_LANES;
  localparam int unsigned NUM_CSRS = 1 + NUM_BCOORDS;
  localparam int unsigned WID_W    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int unsigned PID_W    = (NUM_PIDS > 1) ? $clog2(NUM_PIDS) : 1;
  localparam int unsigned CSR_W    = (NUM_CSRS > 1) ? $clog2(NUM_CSRS) : 1;

  logic                              push_valid;
  logic                              push_ready;
  logic [WID_W-1:0]                  push_wid;
  logic [PID_W-1:0]                  push_pid;
  logic [NUM_LANES-1:0]              push_tmask;
  logic [NUM_LANES*POS_BITS-1:0]     push_pos_x;
  logic [NUM_LANES*POS_BITS-1:0]     push_pos_y;
  logic [NUM_LANES*4-1:0]            push_mask;
  logic [NUM_LANES*NUM_BCOORDS*32-1:0] push_bcoords;
  logic                              pop_valid;
  logic [WID_W-1:0]                  pop_wid;
  logic [WID_W-1:0]                  read_wid;
  logic [PID_W-1:0]                  read_pid;
  logic [CSR_W-1:0]                  read_addr;
  logic [NUM_LANES*32-1:0]           read_data;
  logic                              read_valid;

  modport master (
    output push_valid, push_wid, push_pid, push_tmask, push_pos_x, push_pos_y,
           push_mask, push_bcoords, pop_valid, pop_wid, read_wid, read_pid, read_addr,
    input  push_ready, read_data, read_valid
  );

  modport slave (
    input  push_valid, push_wid, push_pid, push_tmask, push_pos_x, push_pos_y,
           push_mask, push_bcoords, pop_valid, pop_wid, read_wid, read_pid, read_addr,
    output push_ready, read_data, read_valid
  );
endinterface

// File: rtl/raster_stamp_queue.sv
// Per-warp ring of DEPTH stamp batches: filled lane-group by lane-group in pid
// order, read combinationally at the head, retired by explicit pop.
module raster_stamp_queue #(
  parameter int unsigned NUM_WARPS   = 4,
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned NUM_LANES   = 4,
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned POS_BITS    = 15,
  parameter int unsigned NUM_BCOORDS = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  raster_stamp_queue_if.slave  bus,
  output logic [NUM_WARPS-1:0] warp_empty,
  output logic [NUM_WARPS-1:0] warp_full,
  output logic                 err_order,
  output logic                 err_underflow
);
  localparam int unsigned NUM_PIDS = NUM_THREADS / NUM_LANES;
  localparam int unsigned NUM_CSRS = 1 + NUM_BCOORDS;
  localparam int unsigned WID_W    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int unsigned PID_W    = (NUM_PIDS > 1) ? $clog2(NUM_PIDS) : 1;
  localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
  localparam int unsigned PM_W     = 2 * POS_BITS + 4;
  localparam int unsigned STAMP_W  = PM_W + 32 * NUM_BCOORDS;

  // Stamp layout: {bcoords[NUM_BCOORDS-1..0], pos_y, pos_x, mask}
  typedef logic [STAMP_W-1:0] stamp_t;

  stamp_t           mem     [NUM_WARPS][DEPTH][NUM_PIDS][NUM_LANES];
  logic [CNT_W-1:0] count_q [NUM_WARPS];
  logic [CNT_W-1:0] count_d [NUM_WARPS];
  logic [PTR_W-1:0] head_q  [NUM_WARPS];
  logic [PTR_W-1:0] head_d  [NUM_WARPS];
  logic [PTR_W-1:0] tail_q  [NUM_WARPS];
  logic [PTR_W-1:0] tail_d  [NUM_WARPS];
  logic [PID_W-1:0] fill_q  [NUM_WARPS];
  logic [PID_W-1:0] fill_d  [NUM_WARPS];

  logic                 ready;
  logic                 push_fire;
  logic                 pid_ok;
  logic                 commit;
  logic [NUM_WARPS-1:0] commit_w;
  logic [NUM_WARPS-1:0] pop_w;
  stamp_t               rd_stamp;
  logic [31:0]          rd_word;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    ready     = count_q[bus.push_wid] != CNT_W'(DEPTH);
    push_fire = bus.push_valid && ready;
    pid_ok    = bus.push_pid == fill_q[bus.push_wid];
    commit    = push_fire && pid_ok && (bus.push_pid == PID_W'(NUM_PIDS - 1));
    bus.push_ready = ready;
  end

  always_comb begin
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      commit_w[w] = commit && (bus.push_wid == WID_W'(w));
      pop_w[w]    = bus.pop_valid && (bus.pop_wid == WID_W'(w)) && (count_q[w] != '0);
      fill_d[w]   = fill_q[w];
      if (push_fire && pid_ok && (bus.push_wid == WID_W'(w)))
        fill_d[w] = commit ? '0 : fill_q[w] + 1'b1;
      tail_d[w]  = commit_w[w] ? ptr_inc(tail_q[w]) : tail_q[w];
      head_d[w]  = pop_w[w] ? ptr_inc(head_q[w]) : head_q[w];
      count_d[w] = count_q[w] + CNT_W'(commit_w[w]) - CNT_W'(pop_w[w]);
      warp_empty[w] = count_q[w] == '0;
      warp_full[w]  = count_q[w] == CNT_W'(DEPTH);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        count_q[w] <= '0;
        head_q[w]  <= '0;
        tail_q[w]  <= '0;
        fill_q[w]  <= '0;
      end
      err_order     <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        count_q[w] <= count_d[w];
        head_q[w]  <= head_d[w];
        tail_q[w]  <= tail_d[w];
        fill_q[w]  <= fill_d[w];
      end
      err_order     <= err_order | (push_fire && !pid_ok);
      err_underflow <= err_underflow | (bus.pop_valid && (count_q[bus.pop_wid] == '0));
    end
  end

  // Stamp storage carries no reset; inactive lanes are stored as zero stamps.
  always_ff @(posedge clk) begin
    if (push_fire && pid_ok) begin
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        mem[bus.push_wid][tail_q[bus.push_wid]][bus.push_pid][i] <= bus.push_tmask[i] ?
          {bus.push_bcoords[i*NUM_BCOORDS*32 +: NUM_BCOORDS*32],
           bus.push_pos_y[i*POS_BITS +: POS_BITS],
           bus.push_pos_x[i*POS_BITS +: POS_BITS],
           bus.push_mask[i*4 +: 4]} : '0;
      end
    end
  end

  // Head view uses registered count, so a batch committing this cycle is not yet visible.
  always_comb begin
    bus.read_valid = count_q[bus.read_wid] != '0;
    bus.read_data  = '0;
    rd_stamp       = '0;
    rd_word        = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      rd_stamp = mem[bus.read_wid][head_q[bus.read_wid]][bus.read_pid][i];
      rd_word  = '0;
      if (bus.read_addr == '0)
        rd_word = 32'(rd_stamp[PM_W-1:0]);
      else if (32'(bus.read_addr) < NUM_CSRS)
        rd_word = rd_stamp[PM_W + 32*(32'(bus.read_addr) - 1) +: 32];
      if (bus.read_valid)
        bus.read_data[i*32 +: 32] = rd_word;
    end
  end
endmodule

// File: tb/tb_raster_stamp_queue.sv
// Directed bench for raster_stamp_queue: 4 warps, 8 threads in two 4-lane pids,
// depth 2, two barycentric words per stamp.
module tb_raster_stamp_queue;
  localparam int unsigned NW = 4;
  localparam int unsigned NT = 8;
  localparam int unsigned NL = 4;
  localparam int unsigned D  = 2;
  localparam int unsigned PB = 15;
  localparam int unsigned NB = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] warp_empty;
  logic [3:0] warp_full;
  logic       err_order;
  logic       err_underflow;
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  raster_stamp_queue_if #(
    .NUM_WARPS(NW), .NUM_THREADS(NT), .NUM_LANES(NL), .POS_BITS(PB), .NUM_BCOORDS(NB)
  ) bus ();

  raster_stamp_queue #(
    .NUM_WARPS(NW), .NUM_THREADS(NT), .NUM_LANES(NL), .DEPTH(D), .POS_BITS(PB), .NUM_BCOORDS(NB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .warp_empty(warp_empty),
    .warp_full(warp_full),
    .err_order(err_order),
    .err_underflow(err_underflow)
  );

  // CSR 0 word: {pos_y, pos_x, mask} with mask in [3:0], x in [18:4], y from bit 19.
  function automatic logic [31:0] pw(input int y, input int x, input int m);
    return 32'((y << 19) | (x << 4) | m);
  endfunction

  function automatic logic [31:0] bcw(input int base, input int k, input int i);
    return 32'((base << 16) | (k << 8) | i);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Lane i: x = base+i, y = base+4+i, mask = F^i, bcoord k = {base, k, i}.
  task automatic drive_push(input logic [1:0] wid, input logic pid, input logic [3:0] tm, input int base);
    bus.push_valid = 1'b1;
    bus.push_wid   = wid;
    bus.push_pid   = pid;
    bus.push_tmask = tm;
    for (int i = 0; i < NL; i++) begin
      bus.push_pos_x[i*PB +: PB] = PB'(base + i);
      bus.push_pos_y[i*PB +: PB] = PB'(base + 4 + i);
      bus.push_mask[i*4 +: 4]    = 4'(15 ^ i);
      for (int k = 0; k < NB; k++)
        bus.push_bcoords[(i*NB + k)*32 +: 32] = bcw(base, k, i);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.push_valid = 1'b0;
    bus.pop_valid  = 1'b0;
    #1;
  endtask

  task automatic read_set(input logic [1:0] wid, input logic pid, input logic [1:0] addr);
    bus.read_wid  = wid;
    bus.read_pid  = pid;
    bus.read_addr = addr;
    #1;
  endtask

  task automatic pop(input logic [1:0] wid);
    bus.pop_valid = 1'b1;
    bus.pop_wid   = wid;
  endtask

  initial begin
    reset            = 1'b0;
    bus.push_valid   = 1'b0;
    bus.push_wid     = '0;
    bus.push_pid     = '0;
    bus.push_tmask   = '0;
    bus.push_pos_x   = '0;
    bus.push_pos_y   = '0;
    bus.push_mask    = '0;
    bus.push_bcoords = '0;
    bus.pop_valid    = 1'b0;
    bus.pop_wid      = '0;
    bus.read_wid     = '0;
    bus.read_pid     = '0;
    bus.read_addr    = '0;
    #3;
    chk("rst_push_ready", bus.push_ready, 1);
    chk("rst_read_valid", bus.read_valid, 0);
    chk("rst_read_data", bus.read_data, 0);
    chk("rst_warp_empty", warp_empty, 4'hF);
    chk("rst_warp_full", warp_full, 4'h0);
    chk("rst_err_order", err_order, 0);
    chk("rst_err_underflow", err_underflow, 0);
    #4;
    reset = 1'b1;
    tick();

    // Basic batch into warp 1; commit into an empty warp is invisible in its own cycle.
    drive_push(2'd1, 1'b0, 4'hF, 1);
    tick();
    drive_push(2'd1, 1'b1, 4'hF, 9);
    read_set(2'd1, 1'b0, 2'd0);
    chk("commit_cycle_valid", bus.read_valid, 0);
    chk("commit_cycle_data", bus.read_data, 0);
    tick();
    chk("t1_read_valid", bus.read_valid, 1);
    chk("t1_lane0_pos", bus.read_data[0 +: 32], pw(5, 1, 15));
    chk("t1_lane3_pos", bus.read_data[96 +: 32], pw(8, 4, 12));
    chk("t1_warp_empty", warp_empty, 4'b1101);
    read_set(2'd1, 1'b1, 2'd2);
    chk("t1_pid1_bc1_lane2", bus.read_data[64 +: 32], bcw(9, 1, 2));

    // Fill warp 0 to DEPTH, back-pressure, then pop.
    drive_push(2'd0, 1'b0, 4'hF, 20); tick();
    drive_push(2'd0, 1'b1, 4'hF, 28); tick();
    drive_push(2'd0, 1'b0, 4'hF, 40); tick();
    drive_push(2'd0, 1'b1, 4'hF, 48); tick();
    chk("t2_warp_full", warp_full, 4'b0001);
    chk("t2_ready_full", bus.push_ready, 0);
    drive_push(2'd0, 1'b0, 4'hF, 200); tick();
    drive_push(2'd2, 1'b0, 4'hF, 50);
    #1;
    chk("t2_ready_w2", bus.push_ready, 1);
    tick();
    bus.push_wid = 2'd0;
    pop(2'd0);
    read_set(2'd0, 1'b0, 2'd0);
    chk("t2_no_bypass", bus.push_ready, 0);
    chk("t2_prepop_head", bus.read_data[0 +: 32], pw(24, 20, 15));
    tick();
    chk("t2_ready_after_pop", bus.push_ready, 1);
    chk("t2_not_full", warp_full, 4'b0000);
    chk("t2_second_batch", bus.read_data[0 +: 32], pw(44, 40, 15));
    read_set(2'd0, 1'b1, 2'd1);
    chk("t2_second_pid1_bc0", bus.read_data[32 +: 32], bcw(48, 0, 1));
    drive_push(2'd2, 1'b1, 4'hF, 58); tick();
    chk("t2_empty_vec", warp_empty, 4'b1000);
    read_set(2'd2, 1'b0, 2'd0);
    chk("t2_w2_lane1", bus.read_data[32 +: 32], pw(55, 51, 14));

    // Out-of-order pid is dropped and flagged; a correct sequence then commits.
    drive_push(2'd3, 1'b1, 4'hF, 99); tick();
    chk("t3_err_order", err_order, 1);
    chk("t3_w3_still_empty", warp_empty, 4'b1000);
    chk("t3_no_underflow", err_underflow, 0);
    drive_push(2'd3, 1'b0, 4'hF, 70); tick();
    drive_push(2'd3, 1'b1, 4'hF, 78); tick();
    chk("t3_commit", warp_empty, 4'b0000);
    read_set(2'd3, 1'b1, 2'd0);
    chk("t3_read", bus.read_data[0 +: 32], pw(82, 78, 15));

    // Underflow on an empty warp, then asynchronous reset clears flags.
    pop(2'd3); tick();
    chk("t4_pop_ok", warp_empty, 4'b1000);
    chk("t4_no_underflow_yet", err_underflow, 0);
    pop(2'd3); tick();
    chk("t4_underflow", err_underflow, 1);
    chk("t4_counts_same", warp_empty, 4'b1000);
    chk("t4_full_same", warp_full, 4'b0000);
    reset = 1'b0;
    #1;
    chk("t4_async_err_order", err_order, 0);
    chk("t4_async_err_underflow", err_underflow, 0);
    chk("t4_async_empty", warp_empty, 4'hF);
    chk("t4_async_read_valid", bus.read_valid, 0);
    #2;
    reset = 1'b1;
    tick();

    // Commit and pop on the same warp in the same cycle.
    drive_push(2'd0, 1'b0, 4'hF, 100); tick();
    drive_push(2'd0, 1'b1, 4'hF, 108); tick();
    chk("t5_one_batch", warp_empty, 4'b1110);
    drive_push(2'd0, 1'b0, 4'hF, 120); tick();
    drive_push(2'd0, 1'b1, 4'hF, 128);
    pop(2'd0);
    read_set(2'd0, 1'b0, 2'd0);
    chk("t5_prepop", bus.read_data[0 +: 32], pw(104, 100, 15));
    tick();
    chk("t5_count_kept_empty", warp_empty, 4'b1110);
    chk("t5_count_kept_full", warp_full, 4'b0000);
    chk("t5_new_head", bus.read_data[0 +: 32], pw(124, 120, 15));
    read_set(2'd0, 1'b1, 2'd2);
    chk("t5_new_head_bc1", bus.read_data[64 +: 32], bcw(128, 1, 2));
    pop(2'd0); tick();
    chk("t5_count_was_one", warp_empty, 4'hF);

    // Partial thread mask and out-of-range CSR.
    drive_push(2'd1, 1'b0, 4'b0101, 140); tick();
    drive_push(2'd1, 1'b1, 4'b0101, 148); tick();
    read_set(2'd1, 1'b0, 2'd1);
    chk("t6_tmask_bc0", bus.read_data, {32'h0, bcw(140, 0, 2), 32'h0, bcw(140, 0, 0)});
    read_set(2'd1, 1'b0, 2'd3);
    chk("t6_addr_oob", bus.read_data, 0);
    read_set(2'd1, 1'b0, 2'd0);
    chk("t6_tmask_pos", bus.read_data[63:0], {32'h0, pw(144, 140, 15)});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
